spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  Single-clock SPI master sequencer driving the codebase SPI slaves on the shared sclk.
//  Accepts one transfer request (write, read or full duplex) and drives select/write_en/read_en/MOSI.
//  Shifts tx_data out MSB first, and assembles MISO LSB first to match the slave bit order.
//  Sits between the host/register interface (start, tx_data, rx_data) and up to NUM_SLAVES slaves.
// PARAMETERS
//  DATA_W      8   bits per transfer (slave word width)
//  NUM_SLAVES  4   number of one-hot select lines
//  SEL_W       2   width of slave_id, >= clog2(NUM_SLAVES)
// PORTS
//  sclk      in   1           system/SPI clock, all logic on posedge
//  rst       in   1           synchronous, active-low reset
//  start     in   1           transfer request, sampled only in IDLE
//  mode      in   2           01 write, 10 read, 11 duplex, 00 no-op
//  slave_id  in   SEL_W       target slave index
//  tx_data   in   DATA_W      word to send, captured at accept
//  MISO      in   1           serial data from the selected slave
//  select    out  NUM_SLAVES  one-hot slave select
//  write_en  out  1           master->slave shift enable
//  read_en   out  1           slave->master shift enable
//  MOSI      out  1           serial data to slave
//  rx_data   out  DATA_W      received word, updated only with done
//  busy      out  1           high from accept until the done cycle
//  done      out  1           one-cycle completion pulse
// BEHAVIOUR
//  Reset (rst=0 at posedge): all outputs 0, state IDLE, counters/shift regs 0; a transfer in progress is aborted.
//  States: IDLE -> XFER -> (DRAIN if read bit set) -> IDLE. done is registered on entry to IDLE.
//  Accept at edge t0: IDLE & start & mode!=00 & slave_id<NUM_SLAVES. Otherwise start is ignored: no busy, no done.
//  At t0: latch mode/tx_data, select[slave_id]=1, busy=1, write_en=mode[0], read_en=mode[1], MOSI=tx_data[DATA_W-1], bit_cnt=0.
//  XFER edges t0+1..t0+DATA_W-1: MOSI=tx_data[DATA_W-1-i] at edge t0+i; bit_cnt increments.
//  Edge t0+DATA_W: write_en=0, read_en=0, MOSI=0.
//    Write-only: goto IDLE, done=1, busy=0, select=0 at the same edge.
//    Read/duplex: goto DRAIN; select stays high.
//  Read sampling (slave MISO is registered, one-edge latency): bit i of rx captured from MISO at edge t0+2+i, i=0..DATA_W-1.
//  DRAIN edge t0+DATA_W+1: final sample, rx_data<=assembled word, done=1, busy=0, select=0, goto IDLE.
//  Latency start->done: DATA_W edges for write, DATA_W+1 for read/duplex.
//  Duplex: write and read run in the same window; MOSI timing is identical to write-only.
//  done lasts exactly one cycle. rx_data holds its value until the next read/duplex done; write-only leaves rx_data unchanged.
//  Back-to-back: start sampled in the done cycle (state IDLE) is accepted. The enables were low for one edge, so the slave bit counters reset.
//  start while busy is ignored (no queueing). tx_data/mode/slave_id changes after accept have no effect.
//  Only one select bit is ever high. select never changes while write_en or read_en is high.
//  bit_cnt is clog2(DATA_W) bits; the XFER exit condition is bit_cnt==DATA_W-1 (no wrap beyond).
// TESTING
//  1 Reset: rst=0 for 2 edges mid-duplex -> all outputs 0 next edge; select=0; IDLE; rx_data=0.
//  2 Write 0xA5 to slave 2 -> select=0100, MOSI 1,0,1,0,0,1,0,1 at edges t0..t0+7; done at t0+8; slave data_out=0xA5.
//  3 Read from slave 0 with slave data_in=0x3C -> read_en high t0..t0+7; done at t0+9; rx_data=0x3C.
//  4 Duplex tx=0x81, slave data_in=0x5A -> slave data_out=0x81 and rx_data=0x5A at the done edge t0+9.
//  5 Back-to-back: start held high; write 0xFF then read -> second accept in the done cycle; slave counters restart; both words correct.
//  6 Illegal requests: mode=00, or slave_id=4 with NUM_SLAVES=4 -> no busy, no select, no done; start during busy is ignored.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI master sequencer: one write, read or duplex transfer per request, MOSI MSB first,
// MISO assembled LSB first with one extra DRAIN edge to absorb the slave's registered MISO.
module spi_master_ctrl #(
    parameter int DATA_W     = 8,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = 2
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      slave_id,
    input  logic [DATA_W-1:0]     tx_data,
    input  logic                  MISO,
    output logic [NUM_SLAVES-1:0] select,
    output logic                  write_en,
    output logic                  read_en,
    output logic                  MOSI,
    output logic [DATA_W-1:0]     rx_data,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [31:0] NUM_SLAVES_U = NUM_SLAVES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic                    wen_q, wen_d;
    logic                    ren_q, ren_d;
    logic                    mosi_q, mosi_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    rd_q, rd_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]       tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]       rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]       rx_data_q, rx_data_d;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        wen_d     = wen_q;
        ren_d     = ren_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_d      = rd_q;
        bit_cnt_d = bit_cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        case (state_q)
            IDLE: begin
                if (start && (mode != 2'b00) && (32'(slave_id) < NUM_SLAVES_U)) begin
                    state_d   = XFER;
                    sel_d     = NUM_SLAVES'(1) << slave_id;
                    busy_d    = 1'b1;
                    wen_d     = mode[0];
                    ren_d     = mode[1];
                    rd_d      = mode[1];
                    mosi_d    = tx_data[DATA_W-1];
                    tx_sh_d   = tx_data << 1;
                    bit_cnt_d = '0;
                    rx_sh_d   = '0;
                end
            end
            XFER: begin
                // MISO lags the enable by one edge, so the first XFER edge carries no data.
                if (rd_q && (bit_cnt_q != '0)) begin
                    rx_sh_d = {MISO, rx_sh_q[DATA_W-1:1]};
                end
                if (bit_cnt_q == LAST_BIT) begin
                    wen_d  = 1'b0;
                    ren_d  = 1'b0;
                    mosi_d = 1'b0;
                    if (rd_q) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        sel_d   = '0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    mosi_d    = tx_sh_q[DATA_W-1];
                    tx_sh_d   = tx_sh_q << 1;
                end
            end
            DRAIN: begin
                rx_data_d = {MISO, rx_sh_q[DATA_W-1:1]};
                done_d    = 1'b1;
                busy_d    = 1'b0;
                sel_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            wen_q     <= 1'b0;
            ren_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_q      <= 1'b0;
            bit_cnt_q <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wen_q     <= wen_d;
            ren_q     <= ren_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_q      <= rd_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign select    = sel_q;
    assign write_en  = wen_q;
    assign read_en   = ren_q;
    assign MOSI      = mosi_q;
    assign rx_data   = rx_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a bench-side SPI slave, a transaction-level reference model
// checked every cycle, and directed transfers with literal expectations.
module tb_spi_master_ctrl;
    logic       sclk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] slave_id = 3'd0;
    logic [7:0] tx_data = 8'h00;
    logic       s_miso;
    logic [3:0] select;
    logic       write_en, read_en, mosi, busy, done;
    logic [7:0] rx_data;
    logic [1:0] state_dbg;

    int n_pass = 0;
    int n_total = 0;
    logic chk_en = 1'b0;

    always #5 sclk = ~sclk;

    spi_master_ctrl #(.DATA_W(8), .NUM_SLAVES(4), .SEL_W(3)) dut (
        .sclk(sclk), .rst(rst), .start(start), .mode(mode), .slave_id(slave_id),
        .tx_data(tx_data), .MISO(s_miso), .select(select), .write_en(write_en),
        .read_en(read_en), .MOSI(mosi), .rx_data(rx_data), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Slave: captures MOSI MSB first, returns slave_din LSB first with registered MISO.
    logic [7:0] slave_din = 8'h00;
    logic [7:0] s_dout;
    logic [2:0] s_cnt;
    always @(posedge sclk) begin
        if (!rst) begin
            s_cnt  <= 3'd0;
            s_miso <= 1'b0;
            s_dout <= 8'h00;
        end else if ((select != 4'b0) && (write_en || read_en)) begin
            if (write_en) s_dout <= {s_dout[6:0], mosi};
            if (read_en)  s_miso <= slave_din[s_cnt];
            s_cnt <= s_cnt + 3'd1;
        end else begin
            s_cnt <= 3'd0;
        end
    end

    // Reference model: outputs as a function of edges elapsed since accept.
    logic       m_active = 1'b0;
    int         m_k, m_len;
    logic [1:0] m_mode;
    logic [2:0] m_id;
    logic [7:0] m_tx, m_rx_word;
    logic [3:0] exp_select;
    logic       exp_wen, exp_ren, exp_mosi, exp_busy, exp_done;
    logic [7:0] exp_rx;

    always @(posedge sclk) begin
        if (!rst) begin
            m_active = 1'b0; m_k = 0;
            exp_select = 4'b0; exp_wen = 0; exp_ren = 0; exp_mosi = 0;
            exp_busy = 0; exp_done = 0; exp_rx = 8'h00;
        end else if (m_active) begin
            m_k++;
            m_len      = m_mode[1] ? 9 : 8;
            exp_done   = (m_k == m_len);
            exp_busy   = !exp_done;
            exp_select = exp_done ? 4'b0 : (4'b0001 << m_id);
            exp_wen    = m_mode[0] && (m_k < 8);
            exp_ren    = m_mode[1] && (m_k < 8);
            exp_mosi   = (m_k < 8) ? m_tx[7-m_k] : 1'b0;
            if (exp_done) begin
                m_active = 1'b0;
                if (m_mode[1]) exp_rx = m_rx_word;
            end
        end else begin
            exp_done = 0; exp_busy = 0; exp_select = 4'b0;
            exp_wen = 0; exp_ren = 0; exp_mosi = 0;
            if (start && (mode != 2'b00) && (slave_id < 3'd4)) begin
                m_active = 1'b1; m_k = 0;
                m_mode = mode; m_id = slave_id; m_tx = tx_data; m_rx_word = slave_din;
                exp_busy = 1; exp_select = 4'b0001 << slave_id;
                exp_wen = mode[0]; exp_ren = mode[1]; exp_mosi = tx_data[7];
            end
        end
    end

    always @(negedge sclk) begin
        if (chk_en) begin
            check("select", 32'(select), 32'(exp_select));
            check("write_en", 32'(write_en), 32'(exp_wen));
            check("read_en", 32'(read_en), 32'(exp_ren));
            check("mosi", 32'(mosi), 32'(exp_mosi));
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("rx_data", 32'(rx_data), 32'(exp_rx));
        end
    end

    // Issues one request at a negedge; returns edges from accept to done, the first select and MOSI bits.
    task automatic run_xfer(input logic [1:0] m, input logic [2:0] id, input logic [7:0] tx,
                            input logic [7:0] din, output int lat, output logic [3:0] sel0,
                            output logic [7:0] mosi_bits);
        slave_din = din; mode = m; slave_id = id; tx_data = tx; start = 1'b1;
        @(negedge sclk);
        start = 1'b0; mode = 2'b11; slave_id = 3'd3; tx_data = ~tx;
        sel0 = select;
        mosi_bits = 8'h00;
        mosi_bits[7] = mosi;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge sclk);
            lat++;
            if (lat < 8) mosi_bits[7-lat] = mosi;
        end
        check("xfer_timeout", 32'(done), 32'd1);
    endtask

    int lat;
    logic [3:0] sel0;
    logic [7:0] mbits;

    initial begin
        repeat (2) @(negedge sclk);
        chk_en = 1'b1;
        rst = 1'b1;
        check("reset_state", 32'(state_dbg), 32'd0);
        @(negedge sclk);

        run_xfer(2'b01, 3'd2, 8'hA5, 8'h00, lat, sel0, mbits);
        check("wr_select", 32'(sel0), 32'h4);
        check("wr_mosi_bits", 32'(mbits), 32'hA5);
        check("wr_latency", 32'(lat), 32'd8);
        check("wr_slave_data", 32'(s_dout), 32'hA5);
        @(negedge sclk);

        run_xfer(2'b10, 3'd0, 8'h00, 8'h3C, lat, sel0, mbits);
        check("rd_select", 32'(sel0), 32'h1);
        check("rd_latency", 32'(lat), 32'd9);
        check("rd_data", 32'(rx_data), 32'h3C);
        @(negedge sclk);

        run_xfer(2'b11, 3'd3, 8'h81, 8'h5A, lat, sel0, mbits);
        check("dx_mosi_bits", 32'(mbits), 32'h81);
        check("dx_latency", 32'(lat), 32'd9);
        check("dx_slave_data", 32'(s_dout), 32'h81);
        check("dx_rx_data", 32'(rx_data), 32'h5A);
        @(negedge sclk);

        // Reset in the middle of a duplex transfer.
        slave_din = 8'h96; mode = 2'b11; slave_id = 3'd1; tx_data = 8'h33; start = 1'b1;
        @(negedge sclk);
        start = 1'b0;
        repeat (3) @(negedge sclk);
        rst = 1'b0;
        repeat (2) @(negedge sclk);
        check("rst_select", 32'(select), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_enables", 32'({write_en, read_en, mosi, done}), 32'h0);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst = 1'b1;
        @(negedge sclk);

        // Back-to-back with start held high; request changes while busy are ignored.
        slave_din = 8'hC3; mode = 2'b01; slave_id = 3'd1; tx_data = 8'hFF; start = 1'b1;
        @(negedge sclk);
        mode = 2'b10; slave_id = 3'd3; tx_data = 8'h00;
        lat = 0;
        while (!done && lat < 20) begin @(negedge sclk); lat++; end
        check("b2b_lat1", 32'(lat), 32'd8);
        check("b2b_slave_data", 32'(s_dout), 32'hFF);
        @(negedge sclk);
        check("b2b_reaccept", 32'(busy), 32'd1);
        check("b2b_select2", 32'(select), 32'h8);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin @(negedge sclk); lat++; end
        check("b2b_lat2", 32'(lat), 32'd9);
        check("b2b_rx_data", 32'(rx_data), 32'hC3);
        @(negedge sclk);

        // Illegal requests.
        mode = 2'b00; slave_id = 3'd0; tx_data = 8'h11; start = 1'b1;
        @(negedge sclk);
        check("noop_busy", 32'(busy), 32'd0);
        mode = 2'b01; slave_id = 3'd4;
        @(negedge sclk);
        check("badid_busy", 32'(busy), 32'd0);
        check("badid_select", 32'(select), 32'h0);
        start = 1'b0;
        repeat (2) @(negedge sclk);
        check("illegal_done", 32'(done), 32'd0);
        check("illegal_rx_kept", 32'(rx_data), 32'hC3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
